// File: rtl/univ_shift_pkg.sv
// +------------------------------------------------------------------+
// | univ_shift_pkg : mode/state encodings and the one-step operator   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package univ_shift_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int MAX_W = 64;

    // Operates on a zero-extended MAX_W vector so one function serves any
    // register width; the caller truncates the result back to its width.
    function automatic logic [MAX_W-1:0] next_q(
        input logic [MAX_W-1:0] q,
        input logic [2:0]       mode,
        input logic             ser_in_l,
        input logic             ser_in_r,
        input int               width
    );
        logic [MAX_W-1:0] msb_pos;
        logic             msb;
        msb_pos = MAX_W'(1) << (width - 1);
        msb     = |(q & msb_pos);
        case (mode)
            MODE_SHL:   next_q = (q << 1) | MAX_W'(ser_in_r);
            MODE_SHR:   next_q = (q >> 1) | (ser_in_l ? msb_pos : '0);
            MODE_ROTL:  next_q = (q << 1) | MAX_W'(msb);
            MODE_ROTR:  next_q = (q >> 1) | (q[0] ? msb_pos : '0);
            MODE_ASR:   next_q = (q >> 1) | (msb ? msb_pos : '0);
            MODE_CLEAR: next_q = '0;
            default:    next_q = q;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/usr_step_unit.sv
// +------------------------------------------------------------------+
// | usr_step_unit : combinational single-step shift/rotate operator   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module usr_step_unit
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [2:0]       i_mode,
    input  logic             i_ser_in_l,
    input  logic             i_ser_in_r,
    output logic [WIDTH-1:0] o_q_next
);

    assign o_q_next = WIDTH'(next_q(MAX_W'(i_q), i_mode, i_ser_in_l, i_ser_in_r, WIDTH));

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// +------------------------------------------------------------------+
// | univ_shift_reg : universal register with multi-step run engine    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    state_t           r_state_q, w_state_d;
    logic [2:0]       r_mode_q,  w_mode_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0] r_data_q,  w_data_d;
    logic             r_done_q,  w_done_d;
    logic [WIDTH-1:0] w_step;
    logic [2:0]       w_op_mode;
    logic             w_single_op;

    assign w_op_mode   = (r_state_q == ST_RUN) ? r_mode_q : mode;
    assign w_single_op = (mode == MODE_HOLD) || (mode == MODE_LOAD) || (mode == MODE_CLEAR);

    usr_step_unit #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_q       (r_data_q),
        .i_mode    (w_op_mode),
        .i_ser_in_l(ser_in_l),
        .i_ser_in_r(ser_in_r),
        .o_q_next  (w_step)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_mode_d  = r_mode_q;
        w_cnt_d   = r_cnt_q;
        w_data_d  = r_data_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    // Single-cycle modes ignore amount and always complete at once
                    if (w_single_op) begin
                        w_data_d = (mode == MODE_LOAD) ? d : w_step;
                        w_done_d = 1'b1;
                    end else if (amount == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_mode_d  = mode;
                        w_cnt_d   = amount;
                        w_state_d = ST_RUN;
                    end
                end else begin
                    w_data_d = (mode == MODE_LOAD) ? d : w_step;
                end
            end
            ST_RUN: begin
                w_data_d = w_step;
                w_cnt_d  = r_cnt_q - CNT_W'(1);
                if (r_cnt_q == CNT_W'(1)) begin
                    w_done_d  = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_mode_q  <= MODE_HOLD;
            r_cnt_q   <= '0;
            r_data_q  <= '0;
            r_done_q  <= 1'b0;
        end else if (en) begin
            r_state_q <= w_state_d;
            r_mode_q  <= w_mode_d;
            r_cnt_q   <= w_cnt_d;
            r_data_q  <= w_data_d;
            r_done_q  <= w_done_d;
        end else begin
            r_done_q  <= 1'b0;
        end
    end

    assign q         = r_data_q;
    assign ser_out_l = r_data_q[WIDTH-1];
    assign ser_out_r = r_data_q[0];
    assign busy      = (r_state_q == ST_RUN);
    assign done      = r_done_q;

endmodule

`default_nettype wire

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register. Successor to the single-bit D flip-flop: a WIDTH-bit register with synchronous load, hold and clear. Supports single-step shift, rotate and arithmetic-shift operations, plus a multi-cycle "shift by N" engine with busy/done handshake. Used as the shared storage/shift element in serial-parallel datapaths and as a teaching/verification target for the bench library.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), width of amount and internal step counter (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  clock enable; low = freeze all state (register, FSM, counter)
mode  input  3  operation select (encoding below)
d  input  WIDTH  parallel load data
ser_in_l  input  1  serial fill bit entering at MSB (right shift)
ser_in_r  input  1  serial fill bit entering at LSB (left shift)
start  input  1  launch multi-cycle run of mode, amount steps
amount  input  CNT_W  step count for a run
q  output  WIDTH  register contents
ser_out_l  output  1  q[WIDTH-1]
ser_out_r  output  1  q[0]
busy  output  1  run in progress
done  output  1  one-cycle pulse on completion of a run

Behaviour:
- Reset: on the clk edge with reset=1: q=0, busy=0, done=0, counter=0, FSM=IDLE. Reset has priority over en, start and mode. Reset mid-run aborts the run with no done pulse.
- Mode encoding:
  - 000 HOLD.
  - 001 LOAD: q<=d.
  - 010 SHL: q<={q[W-2:0],ser_in_r}.
  - 011 SHR: q<={ser_in_l,q[W-1:1]}.
  - 100 ROTL.
  - 101 ROTR.
  - 110 ASR: MSB replicated.
  - 111 CLEAR: q<=0.
- en=0: every register holds, including the FSM and counter. done is forced to 0 on that edge.
- Operations take one cycle. q updates on the edge where the operation is sampled. ser_out_* are combinational from q.
- FSM IDLE:
  - start=1 with mode in 010..110 and amount>0: latch mode and amount, go to RUN, busy<=1.
  - start=1 with amount=0: no change to q; done<=1 on the next edge; stay IDLE.
  - start=1 with mode in {000,001,111}: execute that single op, done<=1, stay IDLE.
  - start=0: execute mode as a direct single-cycle op; done stays 0.
- FSM RUN:
  - Each enabled cycle performs one step of the latched mode. Serial inputs are sampled live each step.
  - Counter decrements every step. On the step where it reaches 0: done<=1, busy<=0, return to IDLE.
  - mode, d, amount and start are ignored while busy (start during busy is dropped, not queued).
  - A run of amount=k completes in exactly k enabled cycles after the start edge. busy is high for those k cycles. done is asserted in the cycle after the final step.
- amount>WIDTH is legal. Rotates wrap modulo WIDTH. Shifts flush fully to fill bits. ASR saturates to all-sign.
- done is a registered single-cycle pulse. Back-to-back start on the cycle done is high is accepted.

Decomposition:
- Package univ_shift_pkg holds:
  - mode encodings as localparams: MODE_HOLD..MODE_CLEAR.
  - FSM state encoding: ST_IDLE, ST_RUN.
  - a function computing next_q(q, mode, ser_in_l, ser_in_r).
- Sub-module usr_step_unit: a purely combinational one-step operator (q, mode, serial ins -> next q). It is shared by the direct path and the RUN path. The top level holds the FSM, counter and register.

Test Plan:
- Reset: load 8'hA5, then reset=1 for one edge -> q=8'h00, busy=0, done=0. Repeat with reset asserted mid-run (amount=5, after 2 steps) -> q=0, no done pulse.
- Direct ops: load 8'b1000_0001, then ROTL -> 8'b0000_0011; ROTR twice -> 8'b1100_0000; ASR -> 8'b1110_0000; SHR with ser_in_l=0 -> 8'b0111_0000; CLEAR -> 0.
- Run: load 8'h01, start with SHL, amount=3, ser_in_r=0 -> busy high exactly 3 cycles, q=8'h08, done pulse one cycle. start held during busy has no effect.
- Enable stall: run ROTR amount=4 on 8'h0F with en dropped for 2 cycles mid-run -> completion delayed by 2 cycles, final q=8'hF0, single done.
- Boundaries: start with amount=0 -> done next cycle, q unchanged. ROTL amount=9 on 8'h01 -> q=8'h02. SHL amount=10 with ser_in_r=1 -> q=8'hFF.
- Back-to-back: issue a second start on the cycle done=1 (SHR amount=2) -> accepted immediately, busy reasserts, correct result.
